rhythm_lane_engine: RTL and testbench

//  Parametrised note-field engine for the rhythm game: N_LANES-wide scrolling note map, per-lane hit judging,

---
 rtl/rhythm_pkg.sv | 25 ++
 rtl/rhythm_note_field.sv | 52 +++++
 rtl/rhythm_lane_engine.sv | 199 +++++++++++++++++++
 tb/tb_rhythm_lane_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rhythm_pkg.sv
// Shared types for the rhythm lane engine: game states, sound command codes and
// the pixel-index helper that defines the dot-matrix map layout.
package rhythm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_PAUSE    = 2'd2,
    ST_GAMEOVER = 2'd3
  } state_e;

  localparam logic [1:0] SND_MUTE    = 2'd0;
  localparam logic [1:0] SND_PERFECT = 2'd1;
  localparam logic [1:0] SND_GOOD    = 2'd2;
  localparam logic [1:0] SND_MISS    = 2'd3;

  // Bit offset of the first pixel of (row, lane) in the flattened map bus.
  function automatic int unsigned pix_idx(input int unsigned row,
                                          input int unsigned lane,
                                          input int unsigned n_lanes,
                                          input int unsigned lane_w);
    return (row * n_lanes + lane) * lane_w;
  endfunction

endpackage

// File: rtl/rhythm_note_field.sv
// Scrolling note map: N_ROWS x N_LANES cells, row 0 is the judgement row.
// Supports full clear, per-lane row-0 clear, and a one-row downward shift with spawn.
module rhythm_note_field
  import rhythm_pkg::*;
#(
  parameter int N_LANES = 4,
  parameter int N_ROWS  = 8,
  parameter int LANE_W  = 2
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic                             i_Clear,
  input  logic [N_LANES-1:0]               i_Row0_Clr,
  input  logic                             i_Shift,
  input  logic [N_LANES-1:0]               i_Spawn_Row,
  output logic [N_LANES-1:0]               o_Row0,
  output logic [N_ROWS*N_LANES*LANE_W-1:0] o_Map_Data
);

  logic [N_ROWS-1:0][N_LANES-1:0] cells_q, cells_d;

  // NOTE: cells_d gets a full default first so no path through this block infers a latch.
  always_comb begin
    cells_d = cells_q;
    if (i_Clear) begin
      cells_d = '0;
    end else begin
      cells_d[0] = cells_q[0] & ~i_Row0_Clr;
      // A shift discards row 0 entirely, so any row-0 clear is subsumed by it.
      if (i_Shift) begin
        for (int r = 0; r < N_ROWS - 1; r++) cells_d[r] = cells_q[r+1];
        cells_d[N_ROWS-1] = i_Spawn_Row;
      end
    end
  end

  // NOTE: the cell array is a plain flop bank, not a RAM, so it is reset to give a blank map.
  // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) cells_q <= '0;
    else        cells_q <= cells_d;
  end

  assign o_Row0 = cells_q[0];

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
      assign o_Map_Data[pix_idx(r, k, N_LANES, LANE_W) +: LANE_W] = {LANE_W{cells_q[r][k]}};
    end
  end

endmodule

// File: rtl/rhythm_lane_engine.sv
// Rhythm game core: game FSM, scroll tick/period counters, per-lane hit judging,
// and score / combo / HP bookkeeping around the scrolling note field.
module rhythm_lane_engine
  import rhythm_pkg::*;
#(
  parameter int N_LANES    = 4,
  parameter int N_ROWS     = 8,
  parameter int LANE_W     = 2,
  parameter int SCORE_W    = 16,
  parameter int HP_MAX     = 10,
  parameter int TICK_BASE  = 25_000_000,
  parameter int TICK_MIN   = 5_000_000,
  parameter int TICK_STEP  = 100_000,
  parameter int SPAWN_THR  = 8,
  parameter int COMBO_X2   = 16,
  parameter int HEAL_EVERY = 32,
  parameter int GO_WAIT    = 150_000_000
) (
  input  logic                             i_Clk,
  input  logic                             i_Rst,
  input  logic [N_LANES-1:0]               i_Pulse,
  input  logic [N_LANES+3:0]               i_Rand_Val,
  input  logic [1:0]                       i_Speed_Opt,
  input  logic                             i_Pause,
  input  logic                             i_View_Mode,
  input  logic                             i_Start_Btn,
  output logic [N_ROWS*N_LANES*LANE_W-1:0] o_Map_Data,
  output logic [SCORE_W-1:0]               o_Score,
  output logic [7:0]                       o_Combo,
  output logic [HP_MAX-1:0]                o_HP,
  output logic [1:0]                       o_State,
  output logic [1:0]                       o_Sound_Cmd
);

  // One counter serves as the scroll tick counter in PLAY and the hold timer in GAMEOVER.
  localparam int CNT_MAX = (TICK_BASE > GO_WAIT) ? TICK_BASE : GO_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PER_W   = $clog2(TICK_BASE + 1);
  localparam int HP_W    = $clog2(HP_MAX + 1);
  localparam int EV_W    = $clog2(2 * N_LANES + 1);
  localparam int ACC_W   = SCORE_W + 1;

  localparam logic [PER_W-1:0] TICK_MIN_V  = PER_W'(TICK_MIN);
  localparam logic [PER_W-1:0] TICK_STEP_V = PER_W'(TICK_STEP);
  localparam logic [CNT_W-1:0] GO_WAIT_V   = CNT_W'(GO_WAIT);
  localparam logic [HP_W-1:0]  HP_MAX_V    = HP_W'(HP_MAX);
  localparam logic [7:0]       COMBO_X2_V  = 8'(COMBO_X2);
  localparam logic [7:0]       HEAL_V      = 8'(HEAL_EVERY);
  localparam logic [3:0]       SPAWN_V     = 4'(SPAWN_THR);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   period_q, period_d;
  logic [SCORE_W-1:0] score_q, score_d, high_q, high_d;
  logic [7:0]         combo_q, combo_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [HP_MAX-1:0]  hp_therm_q, hp_therm_d;
  logic [1:0]         sound_q, sound_d;

  logic               fld_clear, fld_shift;
  logic [N_LANES-1:0] fld_row0_clr, row0, spawn_row;
  logic [N_LANES-1:0] hit_mask, empty_mask, tick_miss;
  logic [EV_W-1:0]    n_hits, n_miss;
  logic [PER_W-1:0]   quarter;
  logic               tick, perfect;
  logic [ACC_W-1:0]   pts, score_sum;
  logic [8:0]         combo_sum;
  logic [7:0]         combo_new;

  assign spawn_row = (i_Rand_Val[3:0] >= SPAWN_V) ? i_Rand_Val[N_LANES+3:4] : '0;

  rhythm_note_field #(
    .N_LANES (N_LANES),
    .N_ROWS  (N_ROWS),
    .LANE_W  (LANE_W)
  ) u_field (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Clear     (fld_clear),
    .i_Row0_Clr  (fld_row0_clr),
    .i_Shift     (fld_shift),
    .i_Spawn_Row (spawn_row),
    .o_Row0      (row0),
    .o_Map_Data  (o_Map_Data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    score_d      = score_q;
    high_d       = high_q;
    combo_d      = combo_q;
    hp_d         = hp_q;
    sound_d      = SND_MUTE;
    fld_clear    = 1'b0;
    fld_row0_clr = '0;
    fld_shift    = 1'b0;

    // Judge arithmetic for a PLAY cycle; only committed in the PLAY branch below.
    hit_mask   = i_Pulse & row0;
    empty_mask = i_Pulse & ~row0;
    tick       = (cnt_q == CNT_W'(period_q));
    tick_miss  = tick ? (row0 & ~hit_mask) : '0;
    n_hits     = '0;
    n_miss     = '0;
    for (int k = 0; k < N_LANES; k++) begin
      n_hits = n_hits + EV_W'(hit_mask[k]);
      n_miss = n_miss + EV_W'(empty_mask[k]) + EV_W'(tick_miss[k]);
    end
    quarter   = period_q >> 2;
    perfect   = (cnt_q > CNT_W'(quarter)) && (cnt_q < CNT_W'(period_q - quarter));
    pts       = ACC_W'(n_hits) * (perfect ? ACC_W'(10) : ACC_W'(5));
    if (combo_q >= COMBO_X2_V) pts = pts << 1;
    score_sum = {1'b0, score_q} + pts;
    combo_sum = {1'b0, combo_q} + 9'(n_hits);
    combo_new = combo_sum[8] ? 8'hFF : combo_sum[7:0];

    unique case (state_q)
      ST_IDLE: begin
        period_d = PER_W'(TICK_BASE >> i_Speed_Opt);
        if (i_Start_Btn) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          combo_d   = '0;
          hp_d      = HP_MAX_V;
          cnt_d     = '0;
          fld_clear = 1'b1;
        end
      end
      ST_PLAY: begin
        if (hp_q == '0) begin
          state_d = ST_GAMEOVER;
          cnt_d   = '0;
          if (score_q > high_q) high_d = score_q;
        end else if (i_Pause) begin
          state_d = ST_PAUSE;
        end else begin
          fld_row0_clr = hit_mask;
          fld_shift    = tick;
          cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
          score_d      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          if (n_miss != '0) begin
            combo_d = '0;
            hp_d    = (int'(n_miss) >= int'(hp_q)) ? '0 : hp_q - HP_W'(n_miss);
          end else begin
            combo_d = combo_new;
            if ((combo_new / HEAL_V) != (combo_q / HEAL_V) && hp_q < HP_MAX_V)
              hp_d = hp_q + HP_W'(1);
          end
          if (n_hits != '0 && period_q > TICK_MIN_V)
            period_d = (period_q - TICK_MIN_V > TICK_STEP_V) ? period_q - TICK_STEP_V : TICK_MIN_V;
          if (n_miss != '0)      sound_d = SND_MISS;
          else if (n_hits != '0) sound_d = perfect ? SND_PERFECT : SND_GOOD;
        end
      end
      ST_PAUSE: begin
        if (!i_Pause) state_d = ST_PLAY;
      end
      ST_GAMEOVER: begin
        if (cnt_q == GO_WAIT_V) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
    endcase

    for (int i = 0; i < HP_MAX; i++) hp_therm_d[i] = (int'(hp_d) > i);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      period_q   <= PER_W'(TICK_BASE);
      score_q    <= '0;
      high_q     <= '0;
      combo_q    <= '0;
      hp_q       <= HP_MAX_V;
      hp_therm_q <= '1;
      sound_q    <= SND_MUTE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      score_q    <= score_d;
      high_q     <= high_d;
      combo_q    <= combo_d;
      hp_q       <= hp_d;
      hp_therm_q <= hp_therm_d;
      sound_q    <= sound_d;
    end
  end

  assign o_Score     = i_View_Mode ? high_q : score_q;
  assign o_Combo     = combo_q;
  assign o_HP        = hp_therm_q;
  assign o_State     = state_q;
  assign o_Sound_Cmd = sound_q;

endmodule

// File: tb/tb_rhythm_lane_engine.sv
// Directed bench for rhythm_lane_engine with shortened timing parameters;
// inputs change and outputs are sampled on the falling clock edge.
module tb_rhythm_lane_engine;

  localparam int NL = 4;
  localparam int NR = 8;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL-1:0]     pulse;
  logic [NL+3:0]     rnd;
  logic [1:0]        spd;
  logic              pause, view, start;
  logic [NR*NL*LW-1:0] map;
  logic [15:0]       score;
  logic [7:0]        combo;
  logic [9:0]        hp;
  logic [1:0]        st;
  logic [1:0]        snd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rhythm_lane_engine #(
    .N_LANES(NL), .N_ROWS(NR), .LANE_W(LW), .SCORE_W(16), .HP_MAX(10),
    .TICK_BASE(16), .TICK_MIN(4), .TICK_STEP(2), .SPAWN_THR(8),
    .COMBO_X2(2), .HEAL_EVERY(4), .GO_WAIT(20)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst_n),
    .i_Pulse     (pulse),
    .i_Rand_Val  (rnd),
    .i_Speed_Opt (spd),
    .i_Pause     (pause),
    .i_View_Mode (view),
    .i_Start_Btn (start),
    .o_Map_Data  (map),
    .o_Score     (score),
    .o_Combo     (combo),
    .o_HP        (hp),
    .o_State     (st),
    .o_Sound_Cmd (snd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] row_of(input logic [63:0] m, input int r);
    logic [3:0] v;
    for (int k = 0; k < NL; k++) v[k] = m[(r * NL + k) * LW];
    return v;
  endfunction

  function automatic logic [63:0] map_row(input int r, input logic [3:0] mask);
    logic [63:0] v = '0;
    for (int k = 0; k < NL; k++)
      for (int p = 0; p < LW; p++) v[(r * NL + k) * LW + p] = mask[k];
    return v;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    pulse = m;
    @(negedge clk);
    pulse = '0;
  endtask

  // Bounded wait for row r to equal m; n = falling edges consumed.
  task automatic wait_row(input string tag, input int r, input logic [3:0] m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (row_of(map, r) !== m && n < 400);
    check(tag, 64'(row_of(map, r)), 64'(m));
  endtask

  task automatic spawn(input logic [3:0] m);
    int n;
    rnd = {m, 4'hF};
    wait_row("spawn_row7", 7, m, n);
    rnd = '0;
  endtask

  task automatic new_game(input logic [1:0] opt);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    spd   = opt;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; pulse = '0; rnd = '0; spd = '0; pause = 0; view = 0; start = 0;

    // Reset values
    step(2);
    check("rst_state", 64'(st), 64'd0);
    check("rst_map", map, 64'd0);
    check("rst_score", 64'(score), 64'd0);
    check("rst_combo", 64'(combo), 64'd0);
    check("rst_hp", 64'(hp), 64'h3FF);
    check("rst_sound", 64'(snd), 64'd0);

    // Start at 4x: period 4 -> first tick 5 cycles after start
    rst_n = 1'b1; spd = 2'd2; start = 1'b1;
    step();
    start = 1'b0;
    check("start_state", 64'(st), 64'd1);
    check("start_hp", 64'(hp), 64'h3FF);
    check("start_score", 64'(score), 64'd0);
    check("start_map", map, 64'd0);
    rnd = {4'b0001, 4'hF};
    wait_row("p4_row7", 7, 4'b0001, n);
    rnd = '0;
    check("p4_tick_cycles", 64'(n), 64'd5);

    // Single perfect hit at cnt=8, period 16 -> 14
    new_game(2'd0);
    spawn(4'b0001);
    wait_row("t2_row0", 0, 4'b0001, n);
    step(8);
    press(4'b0001);
    check("t2_sound", 64'(snd), 64'd1);
    check("t2_score", 64'(score), 64'd10);
    check("t2_combo", 64'(combo), 64'd1);
    check("t2_map", map, 64'd0);
    rnd = {4'b0010, 4'hF};
    wait_row("t2_row7", 7, 4'b0010, n);
    rnd = '0;
    check("t2_period14_ticks", 64'(n), 64'd6);

    // Two good hits in one cycle, then a doubled perfect hit
    new_game(2'd0);
    spawn(4'b0101);
    spawn(4'b0001);
    wait_row("t3_row0", 0, 4'b0101, n);
    step(2);
    press(4'b0101);
    check("t3_sound", 64'(snd), 64'd2);
    check("t3_score", 64'(score), 64'd10);
    check("t3_combo", 64'(combo), 64'd2);
    check("t3_row0_clr", 64'(row_of(map, 0)), 64'd0);
    wait_row("t3_row0b", 0, 4'b0001, n);
    check("t3_period14_ticks", 64'(n), 64'd12);
    step(7);
    press(4'b0001);
    check("t3_x2_sound", 64'(snd), 64'd1);
    check("t3_x2_score", 64'(score), 64'd30);
    check("t3_x2_combo", 64'(combo), 64'd3);

    // Empty press + unhit note on the same tick, then 4-lane hit with heal
    new_game(2'd0);
    spawn(4'b0001);
    spawn(4'b1000);
    spawn(4'b1111);
    wait_row("t4_row0", 0, 4'b0001, n);
    step(8);
    press(4'b0001);
    check("t4_hit_combo", 64'(combo), 64'd1);
    wait_row("t4_row0b", 0, 4'b1000, n);
    step(14);
    press(4'b0010);
    check("t4_miss_hp", 64'(hp), 64'h0FF);
    check("t4_miss_combo", 64'(combo), 64'd0);
    check("t4_miss_sound", 64'(snd), 64'd3);
    check("t4_miss_score", 64'(score), 64'd10);
    check("t4_miss_row0", 64'(row_of(map, 0)), 64'hF);
    press(4'b1111);
    check("t4_heal_hp", 64'(hp), 64'h1FF);
    check("t4_heal_combo", 64'(combo), 64'd4);
    check("t4_heal_score", 64'(score), 64'd30);
    check("t4_heal_sound", 64'(snd), 64'd2);

    // Pause mid-tick for 50 cycles; pulses and start ignored meanwhile
    new_game(2'd0);
    spawn(4'b0100);
    step(5);
    pause = 1'b1;
    step();
    check("pause_state", 64'(st), 64'd2);
    check("pause_map", map, map_row(7, 4'b0100));
    pulse = 4'hF; start = 1'b1;
    step(49);
    pulse = '0; start = 1'b0;
    check("pause_hold_state", 64'(st), 64'd2);
    check("pause_hold_map", map, map_row(7, 4'b0100));
    check("pause_hold_hp", 64'(hp), 64'h3FF);
    pause = 1'b0;
    wait_row("pause_resume_row6", 6, 4'b0100, n);
    check("pause_resume_cycles", 64'(n), 64'd13);
    check("pause_resume_state", 64'(st), 64'd1);

    // Game A: score 20, drain, GAMEOVER, back to IDLE
    new_game(2'd0);
    spawn(4'b0011);
    wait_row("ga_row0", 0, 4'b0011, n);
    step(8);
    press(4'b0011);
    check("ga_score", 64'(score), 64'd20);
    press(4'b1111);
    check("ga_drain1_hp", 64'(hp), 64'h03F);
    check("ga_drain1_sound", 64'(snd), 64'd3);
    press(4'b1111);
    press(4'b1111);
    check("ga_drain3_hp", 64'(hp), 64'h000);
    check("ga_drain3_state", 64'(st), 64'd1);
    step();
    check("ga_go_state", 64'(st), 64'd3);
    step(21);
    check("ga_idle_state", 64'(st), 64'd0);
    view = 1'b1; #1;
    check("ga_high", 64'(score), 64'd20);
    view = 1'b0;

    // Game B (no reset): score 35 beats high 20
    spd = 2'd0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("gb_start_state", 64'(st), 64'd1);
    check("gb_start_score", 64'(score), 64'd0);
    spawn(4'b0001);
    spawn(4'b0111);
    wait_row("gb_row0", 0, 4'b0001, n);
    press(4'b0001);
    check("gb_good_score", 64'(score), 64'd5);
    wait_row("gb_row0b", 0, 4'b0111, n);
    step(7);
    press(4'b0111);
    check("gb_score", 64'(score), 64'd35);
    check("gb_combo", 64'(combo), 64'd4);
    check("gb_hp_cap", 64'(hp), 64'h3FF);
    press(4'b1111);
    press(4'b1111);
    press(4'b1111);
    check("gb_drain_hp", 64'(hp), 64'h000);
    step();
    check("gb_go_state", 64'(st), 64'd3);
    view = 1'b1; #1;
    check("gb_high", 64'(score), 64'd35);
    view = 1'b0;
    step(20);
    check("gb_go_hold", 64'(st), 64'd3);
    step();
    check("gb_idle_state", 64'(st), 64'd0);
    view = 1'b1; #1;
    check("gb_idle_high", 64'(score), 64'd35);
    view = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
